keyboard_key_repeat: RTL and testbench
======================================

Name: keyboard_key_repeat

Overview:
- Multi-key successor of the single-key press-to-pulse block: converts the PS/2 decoder's scan code and make/break level into per-key one-clock pulses.
- Adds optional auto-repeat: a held key re-fires after an initial delay, then periodically, for game movement keys (left/right/down).
- Sits between the keyboard decoder and the game control FSM. One instance serves all control keys.

Parameters:
- NUM_KEYS, 4, number of key channels (>=1).
- SCAN_CODES, {8'h29,8'h6B,8'h74,8'h72}, NUM_KEYS*8-bit packed; channel i code = SCAN_CODES[8*i+7:8*i].
- DELAY_CYCLES, 2_500_000, cycles from first pulse to first repeat pulse (>=2).
- REPEAT_CYCLES, 500_000, cycles between subsequent repeat pulses (>=2).
- REPEAT_MASK, {NUM_KEYS{1'b1}}, bit i=1 enables auto-repeat on channel i.

Ports:
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  synchronous, active-low reset.
- scanCode  input  8  current scan code from the decoder; held between events.
- makeBreak  input  1  1 = key pressed (make), 0 = key released (break); qualifies scanCode.
- signal  output  NUM_KEYS  per-channel one-clock pulse.
- held  output  NUM_KEYS  per-channel level; 1 while the key is considered pressed.

Behaviour:
- Reset: on a sampled rst_n=0, all channels go to IDLE, counters go to 0, and signal and held are 0 in the following cycle.
- Per channel i, match_i = (scanCode == code_i). Matching is evaluated independently. Duplicate codes drive identical channels.
- Channel FSM states: IDLE, PRESS, DELAY, RPT, FIRE.
- IDLE -> PRESS when match_i && makeBreak.
- PRESS -> DELAY (mask bit set and repeat compiled in), else PRESS -> HOLD-equivalent: stay in DELAY with the counter frozen.
- DELAY: the counter counts from 0. On reaching DELAY_CYCLES-2 -> FIRE.
- FIRE -> RPT. RPT: the counter counts from 0. On reaching REPEAT_CYCLES-2 -> FIRE.
- Break: match_i && !makeBreak in any state -> IDLE on the next edge. Break wins over a due FIRE.
- While the same make persists, or on duplicate makes from keyboard typematic, no new PRESS. Only internal timing generates repeats.
- Registered outputs:
  - signal[i] = 1 exactly in PRESS or FIRE.
  - held[i] = 1 in any state except IDLE.
- Timing: make sampled at edge N -> signal[i] high for cycle N+1 (latency 1). Repeats at N+1+DELAY_CYCLES, then every REPEAT_CYCLES.
- Input for a different code leaves the channel state unchanged; counters keep running.
- Counter width: $clog2(max(DELAY_CYCLES,REPEAT_CYCLES)). The counter is cleared on every state entry and never wraps.
- Reset mid-hold: the channel returns to IDLE. If scanCode/makeBreak still show the make after release of reset, a fresh PRESS pulse is generated.
- Simultaneous keys: the decoder presents one code at a time. Other channels stay in their states, so several channels can be held and repeating concurrently, each with its own counter.

Optional Feature:
- Macro: KEYBOARD_AUTO_REPEAT_EN.
- Defined: DELAY/RPT/FIRE logic and counters are built, and REPEAT_MASK applies as above.
- Undefined: counters, DELAY timing, RPT and FIRE are removed. PRESS -> DELAY, which is a pure hold state with no counter. Each make produces exactly one pulse, REPEAT_MASK is ignored, and held behaves the same.

Test Plan:
- Setup: NUM_KEYS=3, SCAN_CODES={8'h72,8'h6B,8'h29}, DELAY_CYCLES=10, REPEAT_CYCLES=4, REPEAT_MASK=3'b110, macro defined.
- Reset: rst_n=0 for 2 cycles with scanCode=0x29, makeBreak=1; then rst_n=1 -> signal=0 and held=0 during reset; signal[0] pulses 1 cycle after the first sampled edge with rst_n=1.
- Single press, no repeat: scanCode=0x29, makeBreak=1 held for 30 cycles -> signal[0] is high for exactly 1 cycle, at N+1; held[0]=1 from N+1 until break; no further pulses.
- Auto-repeat: scanCode=0x6B, make held for 25 cycles, then break -> signal[1] pulses at N+1, N+11, N+15, N+19, N+23 and N+27 only if still held; none after the break edge+1; held[1] drops 1 cycle after the break.
- Break vs due fire: on channel 2, break at the exact edge where FIRE is due (N+10) -> no pulse at N+11; held[2]=0 at N+11.
- Concurrent holds: make 0x6B, then 10 cycles later make 0x72 (0x6B not broken) -> channel 1 keeps its N+11/N+15 cadence; channel 2 starts its own cadence from its make; no cross-talk.
- Macro undefined build: same stimulus as auto-repeat -> signal[1] has exactly one pulse at N+1; held[1] behaves the same.

Source files
------------

// File: rtl/keyboard_key_repeat.sv
// keyboard_key_repeat: per-key make/break level to one-clock pulses; optional auto-repeat when KEYBOARD_AUTO_REPEAT_EN is defined.
// Latency: 1 clock from a sampled make to the first pulse; repeats DELAY_CYCLES later, then every REPEAT_CYCLES.
// Backpressure: none; inputs are qualified every clock and outputs are registered pulses/levels with no handshake.
module keyboard_key_repeat #(
   parameter int                    NUM_KEYS      = 4,
   parameter logic [NUM_KEYS*8-1:0] SCAN_CODES    = {8'h29, 8'h6B, 8'h74, 8'h72},
   parameter int                    DELAY_CYCLES  = 2_500_000,
   parameter int                    REPEAT_CYCLES = 500_000,
   parameter logic [NUM_KEYS-1:0]   REPEAT_MASK   = {NUM_KEYS{1'b1}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          scanCode,
   input  logic                makeBreak,
   output logic [NUM_KEYS-1:0] signal,
   output logic [NUM_KEYS-1:0] held
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRESS = 3'd1,
      S_DELAY = 3'd2,
      S_RPT   = 3'd3,
      S_FIRE  = 3'd4
   } state_t;

`ifdef KEYBOARD_AUTO_REPEAT_EN
   // Counter only ever reaches (cycles - 2), so clog2 of the larger period always fits.
   localparam int            MAX_CYC = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
   localparam int            CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] DLY_END = CW'(DELAY_CYCLES - 2);
   localparam logic [CW-1:0] RPT_END = CW'(REPEAT_CYCLES - 2);
`else
   // Timing parameters have no effect when repeat is compiled out.
   logic w_unused_cfg;
   assign w_unused_cfg = ^{REPEAT_MASK, DELAY_CYCLES[0], REPEAT_CYCLES[0]};
`endif

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      state_t r_state;
      state_t w_state_nxt;
      logic   r_sig;
      logic   r_held;
      logic   w_match;

      assign w_match = (scanCode == SCAN_CODES[8*g +: 8]);

`ifdef KEYBOARD_AUTO_REPEAT_EN
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;

      // Next state and counter: break on this key wins over everything, counter clears on state entry.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         if (w_match && !makeBreak) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_match && makeBreak) begin
                     w_state_nxt = S_PRESS;
                     w_cnt_nxt   = '0;
                  end
               end
               S_PRESS: begin
                  w_state_nxt = S_DELAY;
                  w_cnt_nxt   = '0;
               end
               S_DELAY: begin
                  // Channels without repeat park here with the counter frozen at 0.
                  if (REPEAT_MASK[g]) begin
                     if (r_cnt == DLY_END) begin
                        w_state_nxt = S_FIRE;
                        w_cnt_nxt   = '0;
                     end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                     end
                  end
               end
               S_FIRE: begin
                  w_state_nxt = S_RPT;
                  w_cnt_nxt   = '0;
               end
               S_RPT: begin
                  if (r_cnt == RPT_END) begin
                     w_state_nxt = S_FIRE;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end
               default: begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            endcase
         end
      end

      // Repeat timing counter register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_nxt;
         end
      end
`else
      // Next state without repeat: one pulse per make, DELAY is a plain hold state.
      always_comb begin
         w_state_nxt = r_state;
         if (w_match && !makeBreak) begin
            w_state_nxt = S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_match && makeBreak) begin
                     w_state_nxt = S_PRESS;
                  end
               end
               S_PRESS: w_state_nxt = S_DELAY;
               S_DELAY: w_state_nxt = S_DELAY;
               default: w_state_nxt = S_IDLE;
            endcase
         end
      end
`endif

      // State register plus registered decode of the next state for the outputs.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_state <= S_IDLE;
            r_sig   <= 1'b0;
            r_held  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_sig   <= (w_state_nxt == S_PRESS) || (w_state_nxt == S_FIRE);
            r_held  <= (w_state_nxt != S_IDLE);
         end
      end

      assign signal[g] = r_sig;
      assign held[g]   = r_held;
   end

endmodule

// File: tb/tb_keyboard_key_repeat.sv
// tb_keyboard_key_repeat: directed and randomized stimulus against a timestamp-based reference model.
// Latency: outputs compared every cycle on the falling edge after the model updates.
// Backpressure: not applicable; the bench drives inputs freely on falling edges.
module tb_keyboard_key_repeat;
   localparam int          NK    = 3;
   localparam int          D     = 10;
   localparam int          R     = 4;
   localparam logic [23:0] CODES = {8'h72, 8'h6B, 8'h29};
   localparam logic [2:0]  MASK  = 3'b110;
`ifdef KEYBOARD_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    scanCode;
   logic          makeBreak;
   logic [NK-1:0] signal;
   logic [NK-1:0] held;

   int n_checks = 0;
   int n_pass   = 0;

   keyboard_key_repeat #(
      .NUM_KEYS      (NK),
      .SCAN_CODES    (CODES),
      .DELAY_CYCLES  (D),
      .REPEAT_CYCLES (R),
      .REPEAT_MASK   (MASK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scanCode  (scanCode),
      .makeBreak (makeBreak),
      .signal    (signal),
      .held      (held)
   );

   always #5 clk = ~clk;

   // Reference model: a key is either released or pressed since a known cycle;
   // pulses fall at press time, then D later, then every R while still pressed.
   logic [7:0]    code_tab [NK] = '{8'h29, 8'h6B, 8'h72};
   bit            act [NK]      = '{default: 1'b0};
   int            p_time [NK]   = '{default: 0};
   int            now           = 0;
   logic [NK-1:0] exp_sig       = '0;
   logic [NK-1:0] exp_held      = '0;

   always @(posedge clk) begin
      now = now + 1;
      for (int k = 0; k < NK; k++) begin
         if (!rst_n) begin
            act[k] = 1'b0;
         end else if (scanCode == code_tab[k] && !makeBreak) begin
            act[k] = 1'b0;
         end else if (scanCode == code_tab[k] && makeBreak && !act[k]) begin
            act[k]    = 1'b1;
            p_time[k] = now;
         end
         exp_held[k] = act[k];
         exp_sig[k]  = act[k] && ((now == p_time[k]) ||
                       (REP && MASK[k] && (now - p_time[k] >= D) && ((now - p_time[k] - D) % R == 0)));
      end
   end

   task automatic test_reset();
      rst_n     = 1'b0;
      scanCode  = 8'h29;
      makeBreak = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (signal !== 3'b000 || held !== 3'b000)
            $display("FAIL reset_hold c=%0d signal=%b held=%b expected 000/000", c, signal, held);
         else n_pass++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (signal !== 3'b001 || held !== 3'b001)
         $display("FAIL reset_release signal=%b held=%b expected 001/001", signal, held);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (signal !== 3'b000 || held !== 3'b001)
         $display("FAIL reset_after signal=%b held=%b expected 000/001", signal, held);
      else n_pass++;
   endtask

   task automatic test_single_press();
      int pulses = 0;
      makeBreak = 1'b0;
      scanCode  = 8'h29;
      repeat (3) @(negedge clk);
      makeBreak = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (signal[0]) pulses++;
         n_checks++;
         if (signal !== exp_sig || held !== exp_held)
            $display("FAIL single_model c=%0d signal=%b held=%b expected %b/%b", c, signal, held, exp_sig, exp_held);
         else n_pass++;
         if (c == 1) begin
            n_checks++;
            if (signal[0] !== 1'b1 || held[0] !== 1'b1)
               $display("FAIL single_first signal0=%b held0=%b expected 1/1", signal[0], held[0]);
            else n_pass++;
         end
      end
      n_checks++;
      if (pulses != 1) $display("FAIL single_count pulses=%0d expected 1", pulses);
      else n_pass++;
      makeBreak = 1'b0;
      @(negedge clk);
      n_checks++;
      if (held[0] !== 1'b0 || signal[0] !== 1'b0)
         $display("FAIL single_break held0=%b signal0=%b expected 0/0", held[0], signal[0]);
      else n_pass++;
   endtask

   task automatic test_autorepeat();
      int pulses = 0;
      int exp_pulses;
      exp_pulses = REP ? 5 : 1;
      scanCode   = 8'h6B;
      makeBreak  = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         if (c == 26) makeBreak = 1'b0;
         @(negedge clk);
         if (signal[1]) pulses++;
         n_checks++;
         if (signal !== exp_sig || held !== exp_held)
            $display("FAIL repeat_model c=%0d signal=%b held=%b expected %b/%b", c, signal, held, exp_sig, exp_held);
         else n_pass++;
         if (c == 11 || c == 15) begin
            n_checks++;
            if (signal[1] !== REP)
               $display("FAIL repeat_at c=%0d signal1=%b expected %b", c, signal[1], REP);
            else n_pass++;
         end
         if (c == 25 || c == 26) begin
            n_checks++;
            if (held[1] !== (c == 25))
               $display("FAIL repeat_held c=%0d held1=%b expected %b", c, held[1], (c == 25));
            else n_pass++;
         end
      end
      n_checks++;
      if (pulses != exp_pulses) $display("FAIL repeat_count pulses=%0d expected %0d", pulses, exp_pulses);
      else n_pass++;
   endtask

   task automatic test_break_vs_fire();
      scanCode  = 8'h72;
      makeBreak = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         if (c == 11) makeBreak = 1'b0;
         @(negedge clk);
         n_checks++;
         if (signal !== exp_sig || held !== exp_held)
            $display("FAIL brkfire_model c=%0d signal=%b held=%b expected %b/%b", c, signal, held, exp_sig, exp_held);
         else n_pass++;
         if (c == 11) begin
            n_checks++;
            if (signal[2] !== 1'b0 || held[2] !== 1'b0)
               $display("FAIL brkfire_edge signal2=%b held2=%b expected 0/0", signal[2], held[2]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_concurrent();
      scanCode  = 8'h6B;
      makeBreak = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         if (c == 11) scanCode = 8'h72;
         @(negedge clk);
         n_checks++;
         if (signal !== exp_sig || held !== exp_held)
            $display("FAIL concur_model c=%0d signal=%b held=%b expected %b/%b", c, signal, held, exp_sig, exp_held);
         else n_pass++;
         if (c == 15 || c == 21) begin
            n_checks++;
            if (signal[1] !== (REP && c == 15) || signal[2] !== (REP && c == 21) || held[2:1] !== 2'b11)
               $display("FAIL concur_cadence c=%0d signal=%b held=%b", c, signal, held);
            else n_pass++;
         end
      end
      makeBreak = 1'b0;
      @(negedge clk);
      scanCode = 8'h6B;
      repeat (2) @(negedge clk);
      n_checks++;
      if (held !== 3'b000) $display("FAIL concur_release held=%b expected 000", held);
      else n_pass++;
   endtask

   task automatic test_random();
      int hold_len = 0;
      for (int c = 0; c < 600; c++) begin
         if (hold_len == 0) begin
            hold_len = $urandom_range(1, 30);
            case ($urandom_range(0, 3))
               0: scanCode = 8'h29;
               1: scanCode = 8'h6B;
               2: scanCode = 8'h72;
               default: scanCode = 8'($urandom_range(0, 255));
            endcase
            makeBreak = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 30) != 0);
         end else begin
            hold_len--;
            rst_n = 1'b1;
         end
         @(negedge clk);
         n_checks++;
         if (signal !== exp_sig || held !== exp_held)
            $display("FAIL random_model c=%0d code=%h mb=%b signal=%b held=%b expected %b/%b",
                     c, scanCode, makeBreak, signal, held, exp_sig, exp_held);
         else n_pass++;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_autorepeat();
      test_break_vs_fire();
      test_concurrent();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
